// File: rtl/grid_io_left_multi.sv
// Left-edge IO tile: serial config chain (staging) committed to a shadow register that sets per-channel pad direction/inversion.
// Pad paths are combinational from shadow; ccff_tail lags ccff_head by 2*NUM_IO enabled edges; no backpressure.
module grid_io_left_multi #(
  parameter int NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              config_enable,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_SOC_DIR,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad,
  output logic              config_done,
  output logic              config_error
);

  localparam int L  = 2 * NUM_IO;
  localparam int CW = $clog2(L + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, ACTIVE, ERROR} state_t;

  state_t          state;
  logic [L-1:0]    staging;
  logic [L-1:0]    shadow;
  logic [CW-1:0]   count;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state        <= IDLE;
      staging      <= '0;
      shadow       <= '0;
      count        <= '0;
      config_done  <= 1'b0;
      config_error <= 1'b0;
    end else begin
      if (config_enable) begin
        staging <= {staging[L-2:0], ccff_head};
      end
      case (state)
        SHIFT: begin
          if (config_enable) begin
            // Saturate one past L so any over-length load is still distinguishable.
            if (count != CW'(L + 1)) begin
              count <= count + CW'(1);
            end
          end else if (count == CW'(L)) begin
            shadow      <= staging;
            config_done <= 1'b1;
            state       <= ACTIVE;
          end else begin
            config_error <= 1'b1;
            state        <= ERROR;
          end
        end
        default: begin
          if (config_enable) begin
            state        <= SHIFT;
            count        <= CW'(1);
            config_done  <= 1'b0;
            config_error <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ccff_tail = staging[L-1];

  // Channel k: dir = shadow[2k], inv = shadow[2k+1]; the unused direction is held at 0.
  always_comb begin
    gfpga_pad_EMBEDDED_IO_SOC_DIR = '0;
    gfpga_pad_EMBEDDED_IO_SOC_OUT = '0;
    io_inpad                      = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      gfpga_pad_EMBEDDED_IO_SOC_DIR[k] = shadow[2*k];
      gfpga_pad_EMBEDDED_IO_SOC_OUT[k] = shadow[2*k] & (io_outpad[k] ^ shadow[2*k+1]);
      io_inpad[k] = ~shadow[2*k] & (gfpga_pad_EMBEDDED_IO_SOC_IN[k] ^ shadow[2*k+1]);
    end
  end

endmodule

// File: tb/tb_grid_io_left_multi.sv
// Directed bench for grid_io_left_multi with NUM_IO=4 (chain length 8).
module tb_grid_io_left_multi;

  logic       prog_clk = 1'b0;
  logic       prog_reset_n;
  logic       config_enable;
  logic       ccff_head;
  logic       ccff_tail;
  logic [3:0] soc_in;
  logic [3:0] soc_out;
  logic [3:0] soc_dir;
  logic [3:0] io_outpad;
  logic [3:0] io_inpad;
  logic       config_done;
  logic       config_error;

  int checks = 0;
  int errors = 0;

  grid_io_left_multi #(.NUM_IO(4)) dut (
    .prog_clk                      (prog_clk),
    .prog_reset_n                  (prog_reset_n),
    .config_enable                 (config_enable),
    .ccff_head                     (ccff_head),
    .ccff_tail                     (ccff_tail),
    .gfpga_pad_EMBEDDED_IO_SOC_IN  (soc_in),
    .gfpga_pad_EMBEDDED_IO_SOC_OUT (soc_out),
    .gfpga_pad_EMBEDDED_IO_SOC_DIR (soc_dir),
    .io_outpad                     (io_outpad),
    .io_inpad                      (io_inpad),
    .config_done                   (config_done),
    .config_error                  (config_error)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    config_enable = 1'b1;
    ccff_head     = b;
    tick();
  endtask

  // Shifts bits[7] first, so the byte value equals the final staging content.
  task automatic shift_byte(input logic [7:0] bits);
    for (int i = 7; i >= 0; i--) shift_bit(bits[i]);
  endtask

  task automatic end_load();
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    tick();
  endtask

  initial begin
    prog_reset_n  = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    soc_in        = 4'b1010;
    io_outpad     = 4'b1111;
    tick();
    tick();
    check("rst_dir",   {4'b0, soc_dir},  8'h00);
    check("rst_out",   {4'b0, soc_out},  8'h00);
    check("rst_inpad", {4'b0, io_inpad}, 8'h0a);
    check("rst_done",  {7'b0, config_done},  8'h00);
    check("rst_err",   {7'b0, config_error}, 8'h00);
    check("rst_tail",  {7'b0, ccff_tail},    8'h00);

    // Good load 1,0,1,1,0,0,1,0 -> dir=0100, inv=1101
    prog_reset_n = 1'b1;
    soc_in       = 4'b0000;
    io_outpad    = 4'b0000;
    tick();
    shift_byte(8'b1011_0010);
    check("good_shift_dir",  {4'b0, soc_dir}, 8'h00);
    check("good_shift_done", {7'b0, config_done}, 8'h00);
    check("good_shift_tail", {7'b0, ccff_tail}, 8'h01);
    end_load();
    check("good_done",  {7'b0, config_done},  8'h01);
    check("good_err",   {7'b0, config_error}, 8'h00);
    check("good_dir",   {4'b0, soc_dir},  8'h04);
    check("good_out",   {4'b0, soc_out},  8'h04);
    check("good_inpad", {4'b0, io_inpad}, 8'h09);
    io_outpad = 4'b1111;
    soc_in    = 4'b1111;
    #1;
    check("good_out_ones",   {4'b0, soc_out},  8'h00);
    check("good_inpad_ones", {4'b0, io_inpad}, 8'h02);
    tick();
    tick();
    check("idle_hold_dir",  {4'b0, soc_dir}, 8'h04);
    check("idle_hold_done", {7'b0, config_done}, 8'h01);

    // Short load of 5 bits
    soc_in    = 4'b0000;
    io_outpad = 4'b0000;
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    check("short_shift_dir",  {4'b0, soc_dir}, 8'h04);
    check("short_shift_out",  {4'b0, soc_out}, 8'h04);
    check("short_shift_done", {7'b0, config_done}, 8'h00);
    end_load();
    check("short_err",  {7'b0, config_error}, 8'h01);
    check("short_done", {7'b0, config_done},  8'h00);
    check("short_dir",  {4'b0, soc_dir}, 8'h04);

    // Over-length load of 9 bits, then a correct 0,1,0,1,0,1,0,1 load -> dir=1111, inv=0000
    for (int i = 0; i < 9; i++) shift_bit(1'b1);
    check("over_shift_err", {7'b0, config_error}, 8'h00);
    end_load();
    check("over_err",   {7'b0, config_error}, 8'h01);
    check("over_done",  {7'b0, config_done},  8'h00);
    check("over_dir",   {4'b0, soc_dir},  8'h04);
    check("over_inpad", {4'b0, io_inpad}, 8'h09);
    shift_byte(8'b0101_0101);
    end_load();
    check("reload_err",  {7'b0, config_error}, 8'h00);
    check("reload_done", {7'b0, config_done},  8'h01);
    check("reload_dir",  {4'b0, soc_dir}, 8'h0f);
    io_outpad = 4'b0110;
    soc_in    = 4'b1111;
    #1;
    check("reload_out",   {4'b0, soc_out},  8'h06);
    check("reload_inpad", {4'b0, io_inpad}, 8'h00);

    // Reset after 4 shifts: outputs return to the safe state without a clock edge
    soc_in = 4'b0101;
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
    check("mid_pre_dir", {4'b0, soc_dir}, 8'h0f);
    #2;
    prog_reset_n = 1'b0;
    #1;
    check("mid_rst_dir",   {4'b0, soc_dir},  8'h00);
    check("mid_rst_out",   {4'b0, soc_out},  8'h00);
    check("mid_rst_inpad", {4'b0, io_inpad}, 8'h05);
    check("mid_rst_done",  {7'b0, config_done}, 8'h00);
    check("mid_rst_tail",  {7'b0, ccff_tail},   8'h00);
    config_enable = 1'b0;
    tick();
    prog_reset_n = 1'b1;
    soc_in       = 4'b0000;
    io_outpad    = 4'b0000;
    tick();
    shift_byte(8'b1011_0010);
    end_load();
    check("mid_load_done",  {7'b0, config_done},  8'h01);
    check("mid_load_err",   {7'b0, config_error}, 8'h00);
    check("mid_load_dir",   {4'b0, soc_dir},  8'h04);
    check("mid_load_inpad", {4'b0, io_inpad}, 8'h09);

    // Chain pass-through: a single 1 reaches ccff_tail on the 8th edge
    prog_reset_n = 1'b0;
    #1;
    prog_reset_n = 1'b1;
    tick();
    shift_bit(1'b1);
    check("chain_e1", {7'b0, ccff_tail}, 8'h00);
    for (int i = 2; i <= 7; i++) shift_bit(1'b0);
    check("chain_e7", {7'b0, ccff_tail}, 8'h00);
    shift_bit(1'b0);
    check("chain_e8", {7'b0, ccff_tail}, 8'h01);
    shift_bit(1'b0);
    check("chain_e9", {7'b0, ccff_tail}, 8'h00);
    end_load();
    check("chain_err", {7'b0, config_error}, 8'h01);
    check("chain_dir", {4'b0, soc_dir}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
